// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory (dmem).
// Latency: req sampled at edge E -> ACCESS during E..E+1 -> ack pulse during E+1..E+2.
// Backpressure: req/ack handshake; the losing requester holds req until it is served.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req/we/addr/wdata{0,1}  requester side; req held until its ack
//   ack/err/rdata{0,1}      completion pulse, misalignment flag, read result
//   mem_write_enable/mem_addr/mem_writedata/mem_readdata   dmem side (combinational read)
//   busy, grant             activity flag, index of current/last winner
// Build option: DMEM_ARB_FIXED_PRIORITY_EN -> port 0 always wins contention
//   (default: round-robin).
module dmem_arbiter #(
   parameter int n = 16,
   parameter int r = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         req1,
   input  logic         we0,
   input  logic         we1,
   input  logic [r-1:0] addr0,
   input  logic [r-1:0] addr1,
   input  logic [n-1:0] wdata0,
   input  logic [n-1:0] wdata1,
   output logic         ack0,
   output logic         ack1,
   output logic         err0,
   output logic         err1,
   output logic [n-1:0] rdata0,
   output logic [n-1:0] rdata1,
   output logic         mem_write_enable,
   output logic [r-1:0] mem_addr,
   output logic [n-1:0] mem_writedata,
   input  logic [n-1:0] mem_readdata,
   output logic         busy,
   output logic         grant
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t       state_q;
   logic         we_q;
   logic [r-1:0] addr_q;
   logic [n-1:0] wdata_q;
   logic         grant_q;
   logic         ack0_q, ack1_q;
   logic         err0_q, err1_q;
   logic [n-1:0] rdata0_q, rdata1_q;
   logic         busy_q;
   logic         win_d;
   logic [n-1:0] rd_d;
   logic         misaligned;

`ifndef DMEM_ARB_FIXED_PRIORITY_EN
   logic         last_grant_q;
`endif

   assign misaligned = addr_q[0];

   // Winner: a lone requester always wins; on contention either port 0 (fixed)
   // or the port that was not granted last (round-robin).
   always_comb begin
      win_d = ~req0;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
      if (req0 && req1) begin
         win_d = ~last_grant_q;
      end
`endif
   end

   // Writes and misaligned accesses return zero.
   always_comb begin
      rd_d = mem_readdata;
      if (we_q || misaligned) begin
         rd_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         grant_q  <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         busy_q   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req0 || req1) begin
                  we_q    <= win_d ? we1 : we0;
                  addr_q  <= win_d ? addr1 : addr0;
                  wdata_q <= win_d ? wdata1 : wdata0;
                  grant_q <= win_d;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
                  last_grant_q <= win_d;
`endif
                  busy_q  <= 1'b1;
                  state_q <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (grant_q) begin
                  rdata1_q <= rd_d;
                  err1_q   <= misaligned;
                  ack1_q   <= 1'b1;
               end else begin
                  rdata0_q <= rd_d;
                  err0_q   <= misaligned;
                  ack0_q   <= 1'b1;
               end
               state_q <= S_DONE;
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Reset is folded in combinationally so a reset landing in ACCESS cannot
   // complete the write on the edge that also clears the FSM.
   assign mem_write_enable = (state_q == S_ACCESS) && we_q && !misaligned && !reset;
   // The latches only change at a grant, so the address/data hold outside ACCESS.
   assign mem_addr         = addr_q;
   assign mem_writedata    = wdata_q;
   assign ack0             = ack0_q;
   assign ack1             = ack1_q;
   assign err0             = err0_q;
   assign err1             = err1_q;
   assign rdata0           = rdata0_q;
   assign rdata1           = rdata1_q;
   assign busy             = busy_q;
   assign grant            = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: scoreboard of expected acks fed by a transaction-level
// reference model (memory array + arbitration rule), checked by an independent monitor.
// Includes a behavioural dmem with combinational read and clocked write.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1, err0, err1;
   logic [15:0] rdata0, rdata1;
   logic        mem_write_enable;
   logic [15:0] mem_addr, mem_writedata, mem_readdata;
   logic        busy, grant;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .busy(busy), .grant(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Environment memory (the real dmem stand-in)
   logic [15:0] dmem [0:32767];
   assign mem_readdata = dmem[mem_addr[15:1]];
   always @(posedge clk) if (mem_write_enable) dmem[mem_addr[15:1]] <= mem_writedata;

   // Reference model state
   logic [15:0] ref_mem [0:32767];
   logic        last_m;

   typedef struct {
      int          port;
      logic        err;
      logic [15:0] rdata;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_wr_q[$];

   int n_vec  = 0;
   int n_fail = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void fail(input string msg);
      n_vec++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", msg, cyc);
   endfunction

   // Monitor: pops the scoreboard on every ack and every memory write
   always @(negedge clk) begin
      if (mem_write_enable) begin
         if (exp_wr_q.size() == 0) begin
            fail($sformatf("unexpected_write addr=%h data=%h", mem_addr, mem_writedata));
         end else begin
            logic [31:0] w;
            w = exp_wr_q.pop_front();
            check("write_addr_data", {mem_addr, mem_writedata}, w);
         end
      end
      if (ack0 && ack1) fail("both_acks_high");
      if (ack0 || ack1) begin
         int p;
         p = ack1 ? 1 : 0;
         if (exp_q.size() == 0) begin
            fail($sformatf("unexpected_ack port=%0d", p));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ack_port", p, e.port);
            check("ack_cycle", cyc, e.cyc);
            check("ack_err", p ? err1 : err0, e.err);
            check("ack_rdata", p ? rdata1 : rdata0, e.rdata);
            check("ack_grant", grant, e.port);
            check("ack_busy", busy, 1);
         end
      end
   end

   // Issue one round at a negedge with the DUT idle; both ports may request.
   task automatic run_round(input bit r0, input bit w0, input logic [15:0] a0, input logic [15:0] d0,
                            input bit r1, input bit w1, input logic [15:0] a1, input logic [15:0] d1,
                            input int gap);
      int          order[$];
      int          start;
      bit          pend0, pend1;
      start = cyc;
      if (r0 && r1) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
         order = '{0, 1};
`else
         if (last_m) order = '{0, 1};
         else        order = '{1, 0};
`endif
      end else if (r0) begin
         order = '{0};
      end else if (r1) begin
         order = '{1};
      end
      foreach (order[k]) begin
         exp_t        e;
         bit          we;
         logic [15:0] a, d;
         e.port = order[k];
         we = (e.port == 1) ? w1 : w0;
         a  = (e.port == 1) ? a1 : a0;
         d  = (e.port == 1) ? d1 : d0;
         e.cyc = start + 2 + 3 * k;
         if (a[0]) begin
            e.err = 1'b1; e.rdata = 16'h0000;
         end else if (we) begin
            ref_mem[a[15:1]] = d;
            e.err = 1'b0; e.rdata = 16'h0000;
            exp_wr_q.push_back({a, d});
         end else begin
            e.err = 1'b0; e.rdata = ref_mem[a[15:1]];
         end
         exp_q.push_back(e);
         last_m = (e.port == 1);
      end
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      pend0 = r0; pend1 = r1;
      for (int t = 0; t < 12 && (pend0 || pend1); t++) begin
         @(negedge clk);
         if (ack0) begin req0 = 1'b0; pend0 = 1'b0; end
         if (ack1) begin req1 = 1'b0; pend1 = 1'b0; end
      end
      if (pend0 || pend1) begin
         fail("round_timeout");
         req0 = 1'b0; req1 = 1'b0;
      end
      @(negedge clk);
      repeat (gap) @(negedge clk);
   endtask

   function automatic logic [15:0] rand_addr();
      logic [3:0] w;
      logic       m;
      w = 4'($urandom_range(0, 7));
      m = ($urandom_range(0, 7) == 0);
      return {11'd0, w, m};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32768; i++) begin
         dmem[i] = 16'h0000;
         ref_mem[i] = 16'h0000;
      end
      last_m = 1'b1;
      reset = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      repeat (3) @(negedge clk);
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_err0", err0, 0);
      check("rst_err1", err1, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_mem_we", mem_write_enable, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_writedata, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      reset = 1'b0;
      @(negedge clk);

      // Port 0 write then read back
      run_round(1, 1, 16'h0002, 16'hA5A5, 0, 0, 16'h0, 16'h0, 0);
      run_round(1, 0, 16'h0002, 16'h0000, 0, 0, 16'h0, 16'h0, 0);
      // Pre-write 0x0000 and read 0x0002 on port 1
      run_round(1, 1, 16'h0000, 16'hFFFF, 0, 0, 16'h0, 16'h0, 1);
      run_round(0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0, 0);
      // Misaligned write on port 1 must not touch memory
      run_round(0, 0, 16'h0, 16'h0, 1, 1, 16'h0003, 16'h1234, 0);
      check("misaligned_mem", dmem[1], 16'hA5A5);

      // Reset asserted during ACCESS of a write
      req0 = 1; we0 = 1; addr0 = 16'h0000; wdata0 = 16'h5555;
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      check("rstacc_busy", busy, 1);
      check("rstacc_we", mem_write_enable, 0);
      @(negedge clk);
      req0 = 0; we0 = 0; wdata0 = 0;
      check("rstacc_ack0", ack0, 0);
      check("rstacc_busy_after", busy, 0);
      check("rstacc_rdata1", rdata1, 0);
      check("rstacc_mem_wdata", mem_writedata, 0);
      check("rstacc_grant", grant, 0);
      reset = 1'b0;
      last_m = 1'b1;
      repeat (3) @(negedge clk);
      check("rstacc_mem0", dmem[0], 16'hFFFF);

      // Simultaneous reads: port 0 first after reset
      run_round(1, 0, 16'h0000, 16'h0, 1, 0, 16'h0002, 16'h0, 0);
      // Continuous contention: six transactions
      for (int i = 0; i < 3; i++) begin
         run_round(1, 0, 16'h0002, 16'h0, 1, 0, 16'h0000, 16'h0, 0);
      end

      // Randomized rounds
      for (int i = 0; i < 40; i++) begin
         int mask;
         mask = $urandom_range(1, 3);
         run_round(mask[0], 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom),
                   mask[1], 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom),
                   $urandom_range(0, 2));
      end

      repeat (4) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      check("exp_wr_drained", exp_wr_q.size(), 0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("final_mem[%0d]", i), dmem[i], ref_mem[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
